// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: a DEPTH-entry circular FIFO of
// {pc, instr} pairs with valid/ready on both sides and a single-cycle flush.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PC_W-1:0]            in_pc,
  input  logic [31:0]                in_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            out_pc,
  output logic [31:0]                out_instr,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PC_W-1:0] pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic full, empty, push, pop;

  // in_ready depends only on registered count, never on out_ready.
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = in_valid & ~full & ~flush;
  assign pop   = ~empty & out_ready & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared; pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= in_pc;
      instr_mem[wr_ptr_q] <= in_instr;
    end
  end

  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign out_pc    = empty ? '0 : pc_mem[rd_ptr_q];
  assign out_instr = empty ? '0 : instr_mem[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction buffer between fetch and decode. Holds up to DEPTH {pc, instr} pairs in a circular FIFO, and uses a valid/ready handshake on both sides. The head entry drives the decode stage's instruction input directly. A flush discards all buffered instructions on a branch or JALR redirect.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥ 2
- PC_W, 32, program-counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- flush  in  1  discard all entries this cycle (redirect)
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  queue can accept; equals !full
- in_pc  in  PC_W  PC of the incoming instruction
- in_instr  in  32  raw incoming instruction word
- out_valid  out  1  head entry is valid; equals !empty
- out_ready  in  1  decode consumes the head this cycle
- out_pc  out  PC_W  PC of the head entry
- out_instr  out  32  instruction word of the head entry
- count  out  $clog2(DEPTH+1)  number of occupied entries

## Operation
- Storage: DEPTH-entry array of {pc, instr}, plus wr_ptr and rd_ptr of width $clog2(DEPTH), plus a count register.
- Pointers wrap naturally modulo DEPTH; there is no explicit wrap logic.
- push = in_valid & in_ready & !flush; pop = out_valid & out_ready & !flush.
- On push: the array entry at wr_ptr gets {in_pc, in_instr}, and wr_ptr increments.
- On pop: rd_ptr increments.
- count update:
  - push only: count + 1
  - pop only: count − 1
  - push and pop together: count unchanged
- full = (count == DEPTH); empty = (count == 0).
- in_ready = !full. It is registered-state-derived only and has no combinational path from out_ready. When full, a simultaneous pop does not enable a push that cycle.
- out_valid = !empty.
- out_pc and out_instr are the array entry at rd_ptr when out_valid = 1; both are forced to 0 when empty. Decode therefore sees opcode 0, which it treats as unknown/no-op.
- Flush takes priority over everything in the same cycle:
  - wr_ptr, rd_ptr and count clear to 0
  - any concurrent push or pop is ignored
  - array contents are not cleared
- in_valid while full: no push, no state change. The fetch side must hold in_pc and in_instr until accepted.
- There is no empty bypass: an instruction pushed into an empty queue appears on the outputs the next cycle.

## Timing
- Reset (asynchronous assert) values:
  - wr_ptr = 0, rd_ptr = 0, count = 0
  - out_valid = 0, in_ready = 1
  - out_pc = 0, out_instr = 0
- Reset deassertion is synchronous to clk. The first push is possible in the first clock edge after release.
- Latency from push to visible head: 1 cycle (registered).
- Throughput: 1 push and 1 pop per cycle in steady state when 0 < count < DEPTH.
- After a pop from full, in_ready rises in the next cycle.
- Flush takes effect at the clock edge:
  - the next cycle shows out_valid = 0 and in_ready = 1
  - an instruction presented during the flush cycle is lost and must be re-fetched from the redirect PC
- Reset mid-operation: all state clears immediately; buffered instructions are lost.

## Test plan
- Reset then single push: push pc=0x100, instr=0x00500093 → 1 cycle later out_valid=1, out_pc=0x100, out_instr=0x00500093, count=1; pop → out_valid=0, out_instr=0, count=0.
- Fill and wrap: push 4 instructions (pc 0x0,0x4,0x8,0xC) with out_ready=0 → count=4, in_ready=0; a 5th in_valid is held and not accepted; pop 2 then push 0x10,0x14 → pop order is 0x8,0xC,0x10,0x14 (pointer wrap).
- Simultaneous push/pop at count=2 for 10 cycles → count stays 2, and the output PC sequence is strictly in order with no duplicates or drops.
- Full with simultaneous pop: count=4, in_valid=1, out_ready=1 → one pop, no push, count=3; next cycle in_ready=1.
- Flush with in_valid=1 and out_ready=1 at count=3 → next cycle count=0, out_valid=0, in_ready=1; the flush-cycle instruction does not appear later.
- Asynchronous reset asserted mid-stream at count=2 between clock edges → out_valid=0, count=0, in_ready=1 immediately, without waiting for a clock edge.
